// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry in-order skid FIFO that retires ALU results and
// commits NZCV flags on retire, plus a condition-code evaluator on those flags.
module alu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r1,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_n,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic              in_setflags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r1,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [3:0]        flags_nzcv,
  input  logic [3:0]        cond,
  output logic              cond_pass,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem_r1   [2];
  logic [RD_W-1:0]   mem_rd   [2];
  logic              mem_wen  [2];
  logic [3:0]        mem_nzcv [2];
  logic              mem_setf [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  // in_ready depends only on the state register, so out_ready never reaches it
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = FULL;
        else if (pop && !push) next_state = EMPTY;
      end
      FULL: if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    occupancy = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_r1[i]   <= '0;
        mem_rd[i]   <= '0;
        mem_wen[i]  <= 1'b0;
        mem_nzcv[i] <= 4'b0000;
        mem_setf[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_r1[wr_ptr]   <= in_r1;
        mem_rd[wr_ptr]   <= in_rd;
        mem_wen[wr_ptr]  <= in_wen;
        mem_nzcv[wr_ptr] <= {in_n, in_z, in_c, in_v};
        mem_setf[wr_ptr] <= in_setflags;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Flags commit only when the head entry retires, never on push
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_nzcv <= 4'b0000;
    end else if (pop && mem_setf[rd_ptr]) begin
      flags_nzcv <= mem_nzcv[rd_ptr];
    end
  end

  always_comb begin
    out_r1  = out_valid ? mem_r1[rd_ptr]  : '0;
    out_rd  = out_valid ? mem_rd[rd_ptr]  : '0;
    out_wen = out_valid ? mem_wen[rd_ptr] : 1'b0;
  end

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_nzcv;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc & !fz;
      4'h9: cond_pass = !fc | fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz & (fn == fv);
      4'hD: cond_pass = fz | (fn != fv);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: FIFO ordering, backpressure, flag retire,
// reset mid-operation and a full condition-code sweep.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_r1;
  logic [3:0]  in_rd;
  logic        in_wen;
  logic        in_n, in_z, in_c, in_v;
  logic        in_setflags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r1;
  logic [3:0]  out_rd;
  logic        out_wen;
  logic [3:0]  flags_nzcv;
  logic [3:0]  cond;
  logic        cond_pass;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  alu_wb_stage #(.DATA_W(32), .RD_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r1(in_r1), .in_rd(in_rd), .in_wen(in_wen),
    .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .in_setflags(in_setflags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r1(out_r1), .out_rd(out_rd), .out_wen(out_wen),
    .flags_nzcv(flags_nzcv), .cond(cond), .cond_pass(cond_pass),
    .occupancy(occupancy)
  );

  initial forever #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [31:0] r1,
                               input logic [3:0] rd, input logic wen,
                               input logic [3:0] nzcv, input logic setf);
    in_valid    = valid;
    in_r1       = r1;
    in_rd       = rd;
    in_wen      = wen;
    {in_n, in_z, in_c, in_v} = nzcv;
    in_setflags = setf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCond(input string tag, input logic [3:0] c, input logic exp);
    cond = c;
    #1;
    checkOutput(tag, {31'd0, cond_pass}, {31'd0, exp});
  endtask

  logic [15:0] sweep_exp;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    cond = 4'h0;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'b1111, 1'b1);
    step();
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    #1;

    // Reset state
    checkOutput("rst_occupancy", {30'd0, occupancy}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_flags", {28'd0, flags_nzcv}, 32'd0);
    checkOutput("rst_out_r1", out_r1, 32'd0);
    checkOutput("rst_out_rd", {28'd0, out_rd}, 32'd0);
    checkOutput("rst_out_wen", {31'd0, out_wen}, 32'd0);
    checkCond("rst_cond_NE", 4'h1, 1'b1);
    checkCond("rst_cond_CC", 4'h3, 1'b1);
    checkCond("rst_cond_PL", 4'h5, 1'b1);
    checkCond("rst_cond_VC", 4'h7, 1'b1);
    checkCond("rst_cond_GE", 4'hA, 1'b1);
    checkCond("rst_cond_AL", 4'hE, 1'b1);
    checkCond("rst_cond_NV", 4'hF, 1'b0);
    checkCond("rst_cond_EQ", 4'h0, 1'b0);

    // Single pass through the stage
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h0000_0001, 4'd3, 1'b1, 4'b0000, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    checkOutput("single_occ1", {30'd0, occupancy}, 32'd1);
    checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_r1", out_r1, 32'h1);
    checkOutput("single_rd", {28'd0, out_rd}, 32'd3);
    checkOutput("single_wen", {31'd0, out_wen}, 32'd1);
    step();
    checkOutput("single_occ0", {30'd0, occupancy}, 32'd0);
    checkOutput("single_valid0", {31'd0, out_valid}, 32'd0);
    checkOutput("single_flags", {28'd0, flags_nzcv}, 32'd0);

    // Backpressure: fill, attempt third push, then drain in order
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0004, 4'd1, 1'b1, 4'b1111, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0000_0003, 4'd2, 1'b0, 4'b1111, 1'b0);
    step();
    checkOutput("bp_occ2", {30'd0, occupancy}, 32'd2);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_head", out_r1, 32'h4);
    applyStimulus(1'b1, 32'h0000_0099, 4'd7, 1'b1, 4'b1111, 1'b1);
    step();
    checkOutput("bp_third_occ", {30'd0, occupancy}, 32'd2);
    checkOutput("bp_stable_r1", out_r1, 32'h4);
    checkOutput("bp_stable_rd", {28'd0, out_rd}, 32'd1);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    out_ready = 1'b1;
    step();
    checkOutput("bp_drain_occ1", {30'd0, occupancy}, 32'd1);
    checkOutput("bp_second_r1", out_r1, 32'h3);
    checkOutput("bp_second_rd", {28'd0, out_rd}, 32'd2);
    checkOutput("bp_second_wen", {31'd0, out_wen}, 32'd0);
    step();
    checkOutput("bp_drain_occ0", {30'd0, occupancy}, 32'd0);
    checkOutput("bp_flags", {28'd0, flags_nzcv}, 32'd0);

    // Flags load on retire, not on push
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h8000_0000, 4'd5, 1'b1, 4'b1000, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    checkOutput("fl_push_flags", {28'd0, flags_nzcv}, 32'd0);
    step();
    checkOutput("fl_hold_flags", {28'd0, flags_nzcv}, 32'd0);
    checkOutput("fl_hold_r1", out_r1, 32'h8000_0000);
    out_ready = 1'b1;
    step();
    checkOutput("fl_retire_flags", {28'd0, flags_nzcv}, 32'h8);
    checkCond("fl_cond_MI", 4'h4, 1'b1);
    checkCond("fl_cond_PL", 4'h5, 1'b0);

    // setflags=0 entry leaves flags untouched
    applyStimulus(1'b1, 32'h0000_0000, 4'd6, 1'b1, 4'b0100, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    step();
    checkOutput("nosf_flags", {28'd0, flags_nzcv}, 32'h8);
    checkCond("nosf_cond_EQ", 4'h0, 1'b0);

    // Steady stream: simultaneous push and pop keeps occupancy at 1
    applyStimulus(1'b1, 32'h0000_0010, 4'd0, 1'b1, 4'b0000, 1'b0);
    step();
    for (int i = 1; i < 6; i++) begin
      checkOutput("stream_occ", {30'd0, occupancy}, 32'd1);
      checkOutput("stream_head", out_r1, 32'h10 + 32'(i - 1));
      applyStimulus(1'b1, 32'h10 + 32'(i), 4'(i), 1'b1, 4'b0000, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    step();
    checkOutput("stream_end_occ", {30'd0, occupancy}, 32'd0);
    checkOutput("stream_flags", {28'd0, flags_nzcv}, 32'h8);

    // Reset while FULL discards entries and clears flags
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0AAA, 4'd9, 1'b1, 4'b0011, 1'b1);
    step();
    step();
    checkOutput("prerst_occ", {30'd0, occupancy}, 32'd2);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    #1;
    checkOutput("midrst_occ", {30'd0, occupancy}, 32'd0);
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_flags", {28'd0, flags_nzcv}, 32'd0);

    // Condition sweep with flags 0110
    applyStimulus(1'b1, 32'h1234_5678, 4'd1, 1'b0, 4'b0110, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    step();
    checkOutput("sweep_a_flags", {28'd0, flags_nzcv}, 32'h6);
    sweep_exp = 16'h66A5;
    for (int c = 0; c < 16; c++) begin
      checkCond("sweep_0110", 4'(c), sweep_exp[c]);
    end

    // Condition sweep with flags 1001
    applyStimulus(1'b1, 32'h8765_4321, 4'd2, 1'b0, 4'b1001, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 4'b0000, 1'b0);
    step();
    checkOutput("sweep_b_flags", {28'd0, flags_nzcv}, 32'h9);
    sweep_exp = 16'h565A;
    for (int c = 0; c < 16; c++) begin
      checkCond("sweep_1001", 4'(c), sweep_exp[c]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, result width.
REQ-002 Parameter RD_W, default 4, destination register index width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  ALU result present on in_* this cycle.
REQ-006 in_ready  output  1  stage accepts an entry this cycle.
REQ-007 in_r1  input  DATA_W  ALU result (r1).
REQ-008 in_rd  input  RD_W  destination register index.
REQ-009 in_wen  input  1  result to be written to register file.
REQ-010 in_n, in_z, in_c, in_v  input  1 each  ALU flags for this result.
REQ-011 in_setflags  input  1  entry updates architectural flags on retire.
REQ-012 out_valid  output  1  head entry valid on out_*.
REQ-013 out_ready  input  1  writeback consumes head entry this cycle.
REQ-014 out_r1 / out_rd / out_wen  output  DATA_W / RD_W / 1  head entry fields.
REQ-015 flags_nzcv  output  4  architectural flags {N,Z,C,V}, bit 3 = N.
REQ-016 cond  input  4  condition code to evaluate.
REQ-017 cond_pass  output  1  cond evaluated against flags_nzcv.
REQ-018 occupancy  output  2  entries held (0..2).

Function
REQ-019 Stage SHALL be a 2-entry in-order FIFO; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 State SHALL be one of EMPTY (0), ONE (1), FULL (2); occupancy SHALL equal the state encoding.
REQ-021 Transitions: EMPTY->ONE on push; ONE->FULL on push&!pop; ONE->EMPTY on pop&!push; ONE stays on push&pop; FULL->ONE on pop; all others hold.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, registered-derived only (no combinational path from out_ready).
REQ-023 In FULL with pop, no push SHALL occur that cycle; in_valid is ignored when in_ready=0.
REQ-024 out_valid SHALL be 1 iff state != EMPTY; out_* SHALL present the oldest entry and stay stable while out_valid & !out_ready.
REQ-025 Latency: an entry pushed at edge k SHALL appear on out_* after edge k when the FIFO was EMPTY (1 cycle); no combinational in->out path.
REQ-026 Simultaneous push & pop in ONE SHALL retire the old entry and make the new entry head at the same edge.
REQ-027 All fields (r1, rd, wen, n, z, c, v, setflags) SHALL be stored together per entry; pointers wrap modulo 2.
REQ-028 On pop with stored setflags=1, flags_nzcv SHALL load the entry's {n,z,c,v} at that edge; setflags=0 SHALL leave flags unchanged.
REQ-029 flags SHALL update only on pop, never on push.
REQ-030 cond_pass SHALL be combinational from registered flags_nzcv: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-031 Stored data SHALL pass unmodified; no arithmetic on in_r1.

Reset
REQ-032 With rst=1 at an edge: state EMPTY, occupancy 0, out_valid 0, in_ready 1, flags_nzcv 4'b0000, pointers 0; out_r1/out_rd/out_wen 0.
REQ-033 rst SHALL dominate push and pop in the same cycle; in-flight entries are discarded and flags are not updated.
REQ-034 After reset with flags 0000, cond_pass SHALL be 1 for NE, CC, PL, VC, GE, AL and 0 for NV.

Verification
REQ-035 Single pass: push r1=0x00000001, rd=3, wen=1, nzcv=0000, setflags=1, out_ready=1 -> out_valid next cycle with r1=0x1, rd=3; flags 0000 after pop; occupancy 0->1->0.
REQ-036 Backpressure: out_ready=0, push 0x00000004 then 0x00000003 -> occupancy 2, in_ready 0, third push ignored; release out_ready -> outputs 0x4 then 0x3 in order.
REQ-037 Flags on retire: push r1=0x80000000 nzcv=1000 setflags=1 with out_ready=0 -> flags stay 0000; assert out_ready -> flags 1000, cond MI passes, PL fails.
REQ-038 setflags=0: retire r1=0x00000000 nzcv=0100 setflags=0 after flags=1000 -> flags remain 1000, EQ fails.
REQ-039 Push&pop in ONE and reset mid-operation: steady stream with out_ready=1 holds occupancy 1 every cycle; assert rst while FULL -> next cycle occupancy 0, out_valid 0, flags 0000.
REQ-040 Condition sweep: force flags via retired entries to 0110 and 1001 -> all 16 cond values match REQ-030 table.
